// File: rtl/i2c_slave_byte_engine_pkg.sv
// Shared types for the I2C slave byte engine: transfer direction and FSM state encoding.
package i2c_slave_byte_engine_pkg;

  typedef enum logic {
    DIR_WRITE = 1'b0,
    DIR_READ  = 1'b1
  } DataDirection;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_RX_DATA   = 4'd3,
    ST_RX_ACK    = 4'd4,
    ST_TX_LOAD   = 4'd5,
    ST_TX_DATA   = 4'd6,
    ST_TX_ACK    = 4'd7,
    ST_WAIT_STOP = 4'd8
  } SlaveStateType;

endpackage

// File: rtl/i2c_bus_condition_detect.sv
// SCL edge and START/STOP condition detection on pre-synchronized SCL/SDA.
module i2c_bus_condition_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic r_scl_prev;
  logic r_sda_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= i_scl;
      r_sda_prev <= i_sda;
    end
  end

  assign o_scl_rise = i_scl & ~r_scl_prev;
  assign o_scl_fall = ~i_scl & r_scl_prev;
  assign o_start    = i_scl & r_scl_prev & r_sda_prev & ~i_sda;
  assign o_stop     = i_scl & r_scl_prev & ~r_sda_prev & i_sda;

endmodule

// File: rtl/i2c_slave_byte_engine.sv
// I2C slave byte engine: address match, byte receive/transmit, ACK handling and clock stretching.
module i2c_slave_byte_engine
  import i2c_slave_byte_engine_pkg::*;
#(
  parameter logic GENERAL_CALL_EN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic [6:0] own_address,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_pop,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       sda_out,
  output logic       scl_out,
  output logic       addressed,
  output logic       rw,
  output logic       busy,
  output logic       nack_received
);

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  logic w_addr_match;
  logic [7:0] w_shift_in;

  SlaveStateType r_state;
  logic [7:0] r_shift;
  logic [2:0] r_count;
  logic       r_phase;
  logic [7:0] r_rx_data;
  logic       r_rx_valid, r_tx_pop, r_sda_out, r_scl_out;
  logic       r_addressed, r_rw, r_busy, r_nack;

  i2c_bus_condition_detect u_detect (
    .clk        (clk),
    .rst        (rst),
    .i_scl      (scl_in),
    .i_sda      (sda_in),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  assign w_shift_in   = {r_shift[6:0], sda_in};
  assign w_addr_match = (w_shift_in[7:1] == own_address) ||
                        (GENERAL_CALL_EN && (w_shift_in == 8'h00));

  // r_phase: in ACK states "ACK low is being driven"; in TX_DATA "8th bit clocked";
  // in TX_ACK "master ACK sampled".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '1;
      r_count     <= '0;
      r_phase     <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_tx_pop    <= 1'b0;
      r_sda_out   <= 1'b1;
      r_scl_out   <= 1'b1;
      r_addressed <= 1'b0;
      r_rw        <= 1'b0;
      r_busy      <= 1'b0;
      r_nack      <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_pop   <= 1'b0;
      r_nack     <= 1'b0;
      if (w_start) begin
        r_state     <= ST_ADDR;
        r_count     <= '0;
        r_phase     <= 1'b0;
        r_sda_out   <= 1'b1;
        r_scl_out   <= 1'b1;
        r_addressed <= 1'b0;
        r_busy      <= 1'b1;
      end else if (w_stop) begin
        r_state     <= ST_IDLE;
        r_phase     <= 1'b0;
        r_sda_out   <= 1'b1;
        r_scl_out   <= 1'b1;
        r_addressed <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR: if (w_scl_rise) begin
            r_shift <= w_shift_in;
            r_count <= r_count + 3'd1;
            if (r_count == 3'd7) begin
              if (w_addr_match) begin
                r_rw    <= sda_in;
                r_phase <= 1'b0;
                r_state <= ST_ADDR_ACK;
              end else begin
                r_state <= ST_WAIT_STOP;
              end
            end
          end
          ST_ADDR_ACK, ST_RX_ACK: if (w_scl_fall) begin
            if (!r_phase) begin
              r_sda_out <= 1'b0;
              r_phase   <= 1'b1;
              if (r_state == ST_ADDR_ACK) r_addressed <= 1'b1;
            end else begin
              r_sda_out <= 1'b1;
              r_phase   <= 1'b0;
              r_count   <= '0;
              r_state   <= (r_rw == DIR_READ) ? ST_TX_LOAD : ST_RX_DATA;
            end
          end
          ST_RX_DATA: if (w_scl_rise) begin
            r_shift <= w_shift_in;
            r_count <= r_count + 3'd1;
            if (r_count == 3'd7) begin
              r_rx_data  <= w_shift_in;
              r_rx_valid <= 1'b1;
              r_phase    <= 1'b0;
              r_state    <= ST_RX_ACK;
            end
          end
          ST_TX_LOAD: begin
            if (tx_valid) begin
              r_shift   <= tx_data;
              r_tx_pop  <= 1'b1;
              r_sda_out <= tx_data[7];
              r_scl_out <= 1'b1;
              r_count   <= '0;
              r_phase   <= 1'b0;
              r_state   <= ST_TX_DATA;
            end else begin
              r_scl_out <= 1'b0;
            end
          end
          ST_TX_DATA: begin
            if (w_scl_rise) begin
              r_count <= r_count + 3'd1;
              if (r_count == 3'd7) r_phase <= 1'b1;
            end else if (w_scl_fall) begin
              if (r_phase) begin
                r_sda_out <= 1'b1;
                r_phase   <= 1'b0;
                r_state   <= ST_TX_ACK;
              end else begin
                r_shift   <= {r_shift[6:0], 1'b1};
                r_sda_out <= r_shift[6];
              end
            end
          end
          ST_TX_ACK: begin
            if (w_scl_rise) begin
              if (!sda_in) begin
                r_phase <= 1'b1;
              end else begin
                r_nack  <= 1'b1;
                r_state <= ST_WAIT_STOP;
              end
            end else if (w_scl_fall && r_phase) begin
              r_phase <= 1'b0;
              r_count <= '0;
              r_state <= ST_TX_LOAD;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign tx_pop        = r_tx_pop;
  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign sda_out       = r_sda_out;
  assign scl_out       = r_scl_out;
  assign addressed     = r_addressed;
  assign rw            = r_rw;
  assign busy          = r_busy;
  assign nack_received = r_nack;

endmodule

// File: tb/tb_i2c_slave_byte_engine.sv
// Directed bench for i2c_slave_byte_engine: a bit-level I2C master on a wired-AND bus.
module tb_i2c_slave_byte_engine;
  import i2c_slave_byte_engine_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [6:0] own_address = 7'h5A;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_pop, rx_valid, sda_out, scl_out, addressed, rw, busy, nack_received;
  logic [7:0] rx_data;
  logic       w_scl, w_sda;

  int unsigned compared = 0;
  int unsigned mismatched = 0;
  int unsigned cnt_rx = 0, cnt_pop = 0, cnt_nack = 0, cnt_sda_low = 0;

  assign w_scl = m_scl & scl_out;
  assign w_sda = m_sda & sda_out;

  i2c_slave_byte_engine #(.GENERAL_CALL_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .scl_in(w_scl), .sda_in(w_sda), .own_address(own_address),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_pop(tx_pop), .rx_data(rx_data),
    .rx_valid(rx_valid), .sda_out(sda_out), .scl_out(scl_out), .addressed(addressed),
    .rw(rw), .busy(busy), .nack_received(nack_received)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rx_valid) cnt_rx++;
    if (tx_pop) cnt_pop++;
    if (nack_received) cnt_nack++;
    if (!sda_out) cnt_sda_low++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int unsigned k = 0;
    while (w_scl !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (w_scl !== 1'b1) begin
      compared++; mismatched++;
      $display("FAIL scl_release_timeout: scl=%b required 1", w_scl);
    end
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_sda = b;
    tick(3);
    m_scl = 1'b1;
    wait_scl_high();
    tick(2);
    s = w_sda;
    tick(2);
    m_scl = 1'b0;
    tick(3);
  endtask

  task automatic bus_start();
    m_sda = 1'b1;
    tick(2);
    m_scl = 1'b1;
    wait_scl_high();
    tick(3);
    m_sda = 1'b0;
    tick(3);
    m_scl = 1'b0;
    tick(3);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0;
    tick(2);
    m_scl = 1'b1;
    wait_scl_high();
    tick(3);
    m_sda = 1'b1;
    tick(3);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack, input logic [7:0] next_tx);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      d = {d[6:0], s};
    end
    tx_data = next_tx;
    clock_bit(mack, s);
  endtask

  task automatic test_reset();
    compared++;
    if ({sda_out, scl_out, rx_data, rx_valid, tx_pop, addressed, rw, busy, nack_received} !== 16'b11_00000000_000000) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b required %b",
               {sda_out, scl_out, rx_data, rx_valid, tx_pop, addressed, rw, busy, nack_received}, 16'b11_00000000_000000);
    end
    compared++;
    if (dut.r_state !== ST_IDLE || dut.r_shift !== 8'hFF || dut.r_count !== 3'd0) begin
      mismatched++;
      $display("FAIL reset_internal: state=%0d shift=%h count=%0d required 0/ff/0", dut.r_state, dut.r_shift, dut.r_count);
    end
    tick(2);
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_write();
    logic ack;
    int unsigned rx0;
    bus_start();
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL write_busy: got %b required 1", busy); end
    send_byte(8'hB4, ack);
    compared++;
    if (ack !== 1'b0) begin mismatched++; $display("FAIL write_addr_ack: got %b required 0", ack); end
    compared++;
    if (addressed !== 1'b1 || rw !== 1'b0) begin
      mismatched++; $display("FAIL write_addressed_rw: got %b%b required 10", addressed, rw);
    end
    rx0 = cnt_rx;
    send_byte(8'hA5, ack);
    compared++;
    if (ack !== 1'b0) begin mismatched++; $display("FAIL write_data_ack: got %b required 0", ack); end
    compared++;
    if (rx_data !== 8'hA5) begin mismatched++; $display("FAIL write_rx_data: got %h required a5", rx_data); end
    compared++;
    if (cnt_rx - rx0 !== 1) begin mismatched++; $display("FAIL write_rx_valid_count: got %0d required 1", cnt_rx - rx0); end
    bus_stop();
    compared++;
    if (dut.r_state !== ST_IDLE || busy !== 1'b0 || addressed !== 1'b0) begin
      mismatched++; $display("FAIL write_stop: state=%0d busy=%b addressed=%b required 0/0/0", dut.r_state, busy, addressed);
    end
  endtask

  task automatic test_mismatch(input logic [7:0] addr_byte, input string name);
    logic ack;
    int unsigned low0, rx0;
    low0 = cnt_sda_low;
    rx0 = cnt_rx;
    bus_start();
    send_byte(addr_byte, ack);
    compared++;
    if (ack !== 1'b1) begin mismatched++; $display("FAIL %s_nack: got %b required 1", name, ack); end
    compared++;
    if (dut.r_state !== ST_WAIT_STOP || addressed !== 1'b0) begin
      mismatched++; $display("FAIL %s_wait_stop: state=%0d addressed=%b required 8/0", name, dut.r_state, addressed);
    end
    send_byte(8'h00, ack);
    compared++;
    if (cnt_sda_low != low0 || cnt_rx != rx0 || dut.r_state !== ST_WAIT_STOP) begin
      mismatched++; $display("FAIL %s_ignored: sda_low=%0d rx=%0d state=%0d required 0/0/8",
                             name, cnt_sda_low - low0, cnt_rx - rx0, dut.r_state);
    end
    bus_stop();
    compared++;
    if (dut.r_state !== ST_IDLE || busy !== 1'b0) begin
      mismatched++; $display("FAIL %s_stop: state=%0d busy=%b required 0/0", name, dut.r_state, busy);
    end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] d;
    int unsigned pop0, nack0;
    pop0 = cnt_pop;
    nack0 = cnt_nack;
    tx_valid = 1'b1;
    tx_data = 8'h3C;
    bus_start();
    send_byte(8'hB5, ack);
    compared++;
    if (ack !== 1'b0 || rw !== 1'b1 || addressed !== 1'b1) begin
      mismatched++; $display("FAIL read_addr: ack=%b rw=%b addressed=%b required 0/1/1", ack, rw, addressed);
    end
    read_byte(d, 1'b0, 8'hC3);
    compared++;
    if (d !== 8'h3C) begin mismatched++; $display("FAIL read_byte0: got %h required 3c", d); end
    read_byte(d, 1'b1, 8'h55);
    compared++;
    if (d !== 8'hC3) begin mismatched++; $display("FAIL read_byte1: got %h required c3", d); end
    compared++;
    if (cnt_pop - pop0 !== 2 || cnt_nack - nack0 !== 1) begin
      mismatched++; $display("FAIL read_pulses: pop=%0d nack=%0d required 2/1", cnt_pop - pop0, cnt_nack - nack0);
    end
    compared++;
    if (dut.r_state !== ST_WAIT_STOP || sda_out !== 1'b1) begin
      mismatched++; $display("FAIL read_after_nack: state=%0d sda=%b required 8/1", dut.r_state, sda_out);
    end
    bus_stop();
    tx_valid = 1'b0;
  endtask

  task automatic test_stretch();
    logic ack;
    logic [7:0] d;
    int unsigned pop0, low_cycles;
    tx_valid = 1'b0;
    tx_data = 8'h81;
    pop0 = cnt_pop;
    low_cycles = 0;
    bus_start();
    send_byte(8'hB5, ack);
    for (int i = 0; i < 50; i++) begin
      if (scl_out === 1'b0) low_cycles++;
      tick(1);
    end
    compared++;
    if (low_cycles !== 50 || cnt_pop != pop0) begin
      mismatched++; $display("FAIL stretch_hold: low_cycles=%0d pops=%0d required 50/0", low_cycles, cnt_pop - pop0);
    end
    tx_valid = 1'b1;
    tick(1);
    compared++;
    if (scl_out !== 1'b1 || cnt_pop - pop0 !== 1) begin
      mismatched++; $display("FAIL stretch_release: scl_out=%b pops=%0d required 1/1", scl_out, cnt_pop - pop0);
    end
    tx_valid = 1'b0;
    read_byte(d, 1'b1, 8'h00);
    compared++;
    if (d !== 8'h81) begin mismatched++; $display("FAIL stretch_data: got %h required 81", d); end
    bus_stop();
  endtask

  task automatic test_repeated_start();
    logic ack, s;
    bus_start();
    send_byte(8'hB4, ack);
    clock_bit(1'b1, s);
    clock_bit(1'b0, s);
    clock_bit(1'b1, s);
    clock_bit(1'b1, s);
    compared++;
    if (dut.r_state !== ST_RX_DATA || dut.r_count !== 3'd4) begin
      mismatched++; $display("FAIL rs_mid_byte: state=%0d count=%0d required 3/4", dut.r_state, dut.r_count);
    end
    bus_start();
    compared++;
    if (dut.r_state !== ST_ADDR || dut.r_count !== 3'd0 || addressed !== 1'b0 || busy !== 1'b1) begin
      mismatched++; $display("FAIL rs_restart: state=%0d count=%0d addressed=%b busy=%b required 1/0/0/1",
                             dut.r_state, dut.r_count, addressed, busy);
    end
    bus_stop();
    compared++;
    if (dut.r_state !== ST_IDLE || busy !== 1'b0) begin
      mismatched++; $display("FAIL rs_stop: state=%0d busy=%b required 0/0", dut.r_state, busy);
    end
  endtask

  task automatic test_reset_mid_tx();
    logic ack, s;
    int unsigned low0;
    tx_valid = 1'b1;
    tx_data = 8'h00;
    bus_start();
    send_byte(8'hB5, ack);
    compared++;
    if (dut.r_state !== ST_TX_DATA || sda_out !== 1'b0) begin
      mismatched++; $display("FAIL rst_pre: state=%0d sda=%b required 6/0", dut.r_state, sda_out);
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if (sda_out !== 1'b1) begin mismatched++; $display("FAIL rst_async_sda: got %b required 1", sda_out); end
    compared++;
    if ({scl_out, rx_data, rx_valid, tx_pop, addressed, rw, busy, nack_received} !== 15'b1_00000000_000000 ||
        dut.r_state !== ST_IDLE) begin
      mismatched++; $display("FAIL rst_async_outputs: got %b state=%0d required %b state=0",
                             {scl_out, rx_data, rx_valid, tx_pop, addressed, rw, busy, nack_received},
                             dut.r_state, 15'b1_00000000_000000);
    end
    tx_valid = 1'b0;
    tick(2);
    rst = 1'b0;
    low0 = cnt_sda_low;
    clock_bit(1'b0, s);
    clock_bit(1'b1, s);
    compared++;
    if (dut.r_state !== ST_IDLE || cnt_sda_low != low0) begin
      mismatched++; $display("FAIL rst_idle_ignore: state=%0d sda_low=%0d required 0/0", dut.r_state, cnt_sda_low - low0);
    end
    bus_start();
    send_byte(8'hB4, ack);
    compared++;
    if (ack !== 1'b0 || addressed !== 1'b1) begin
      mismatched++; $display("FAIL rst_resume: ack=%b addressed=%b required 0/1", ack, addressed);
    end
    bus_stop();
  endtask

  initial begin
    tick(3);
    test_reset();
    test_write();
    test_mismatch(8'h66, "mismatch");
    test_mismatch(8'h00, "general_call_off");
    test_read();
    test_stretch();
    test_repeated_start();
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
